// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline control blocks.
// Contents: decoded opcode constants, the always-execute condition code,
// the sequencer FSM state enum, the hazard scoreboard slot record, and a
// helper that tests a source register against one scoreboard slot.
package arm_pkg;

    // Data-processing opcodes (top bit clear)
    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_EOR = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_RSB = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SBC = 5'b00110;
    localparam logic [4:0] OP_RSC = 5'b00111;
    localparam logic [4:0] OP_TST = 5'b01000;
    localparam logic [4:0] OP_TEQ = 5'b01001;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_CMN = 5'b01011;
    localparam logic [4:0] OP_ORR = 5'b01100;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam logic [4:0] OP_BIC = 5'b01110;
    localparam logic [4:0] OP_MVN = 5'b01111;
    // Other instruction classes
    localparam logic [4:0] OP_MEM = 5'b10000;
    localparam logic [4:0] OP_BR  = 5'b10001;
    localparam logic [4:0] OP_NOP = 5'b11111;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] REG_LR  = 4'd14;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic       dst0_v;
        logic [3:0] dst0;
        logic       dst1_v;
        logic [3:0] dst1;
        logic       cpsr_w;
    } sb_slot_t;

    localparam sb_slot_t SB_EMPTY = '{dst0_v: 1'b0, dst0: 4'h0,
                                      dst1_v: 1'b0, dst1: 4'h0,
                                      cpsr_w: 1'b0};

    // True when register r is written by either valid destination of slot s
    function automatic logic slot_hit(input logic [3:0] r, input sb_slot_t s);
        return (s.dst0_v && (s.dst0 == r)) || (s.dst1_v && (s.dst1 == r));
    endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Combinational register-use decoder.
// Maps the decoder's ID-stage fields to which register fields are read
// (use_rn/use_rm/use_rd) and the scoreboard record of what the
// instruction will write (up to two registers plus the CPSR).
// Ports: opcode/rn/rd/rm and control bits in; use_* flags and info out.
module reg_use_decode
    import arm_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [3:0] rn,
    input  logic [3:0] rd,
    input  logic [3:0] rm,
    input  logic       imm_op,
    input  logic       load_store,
    input  logic       write_back,
    input  logic       cpsr_write,
    input  logic       link_bit,
    output logic       use_rn,
    output logic       use_rm,
    output logic       use_rd,
    output sb_slot_t   info
);

    // Source and destination classification per instruction class
    always_comb begin
        use_rn = 1'b0;
        use_rm = 1'b0;
        use_rd = 1'b0;
        info   = SB_EMPTY;
        if (opcode[4] == 1'b0) begin
            // MOV/MVN take only operand 2
            use_rn = (opcode != OP_MOV) && (opcode != OP_MVN);
            use_rm = ~imm_op;
            // Compare/test ops only set flags
            if ((opcode >= OP_TST) && (opcode <= OP_CMN)) begin
                info.dst0_v = 1'b0;
            end else begin
                info.dst0_v = 1'b1;
            end
            info.dst0   = rd;
            info.cpsr_w = cpsr_write;
        end else begin
            case (opcode)
                OP_MEM: begin
                    use_rn      = 1'b1;
                    // For memory ops the immediate bit selects a register offset
                    use_rm      = imm_op;
                    use_rd      = ~load_store;
                    info.dst0_v = load_store;
                    info.dst0   = rd;
                    info.dst1_v = write_back;
                    info.dst1   = rn;
                end
                OP_BR: begin
                    info.dst0_v = link_bit;
                    info.dst0   = REG_LR;
                end
                default: begin
                    info = SB_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard and flush controller for the 5-stage pipeline.
// Tracks in-flight register/CPSR writes in EX and MEM slots, stalls the
// front end on RAW or flag hazards, and flushes on a taken branch for
// FLUSH_CYCLES cycles. Saturating debug counters for stalls and flushes.
// Ports: clk, reset (async active-low), decoder ID fields, ex_branch_taken
// in; stall/bubble/flush (combinational) and the two counters out.
module pipeline_sequencer
    import arm_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dec_opcode,
    input  logic [3:0]  dec_rn,
    input  logic [3:0]  dec_rd,
    input  logic [3:0]  dec_rm,
    input  logic [3:0]  dec_cond,
    input  logic        dec_immediateOperand,
    input  logic        dec_loadStore,
    input  logic        dec_writeBack,
    input  logic        dec_CPSRwrite,
    input  logic        dec_linkBit,
    input  logic        ex_branch_taken,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

    seq_state_e  state_r, state_nx_s;
    logic [2:0]  fcnt_r, fcnt_nx_s, fcnt_cur_s;
    sb_slot_t    ex_r, mem_r, id_info_s, ex_nx_s;
    logic        use_rn_s, use_rm_s, use_rd_s;
    logic        raw_s, flag_s, hazard_s, flushing_s;
    logic [15:0] stall_count_r, flush_count_r;

    reg_use_decode u_decode (
        .opcode     (dec_opcode),
        .rn         (dec_rn),
        .rd         (dec_rd),
        .rm         (dec_rm),
        .imm_op     (dec_immediateOperand),
        .load_store (dec_loadStore),
        .write_back (dec_writeBack),
        .cpsr_write (dec_CPSRwrite),
        .link_bit   (dec_linkBit),
        .use_rn     (use_rn_s),
        .use_rm     (use_rm_s),
        .use_rd     (use_rd_s),
        .info       (id_info_s)
    );

    // Hazard detection against the EX and MEM slots (WB is write-first)
    always_comb begin
        raw_s = (use_rn_s && (slot_hit(dec_rn, ex_r) || slot_hit(dec_rn, mem_r))) ||
                (use_rm_s && (slot_hit(dec_rm, ex_r) || slot_hit(dec_rm, mem_r))) ||
                (use_rd_s && (slot_hit(dec_rd, ex_r) || slot_hit(dec_rd, mem_r)));
        // Flags become valid as soon as the writer leaves EX
        flag_s     = (dec_cond != COND_AL) && ex_r.cpsr_w;
        hazard_s   = raw_s || flag_s;
        flushing_s = ex_branch_taken || (state_r == ST_FLUSH);
    end

    // Pipeline control outputs; flush beats hazard, reset forces a bubble
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (!reset) begin
            bubble = 1'b1;
        end else if (flushing_s) begin
            bubble = 1'b1;
            flush  = 1'b1;
        end else if (hazard_s) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end else begin
            stall  = 1'b0;
        end
    end

    // Next state; the branch cycle itself is flush cycle 1, so the reload
    // value is consumed in the same cycle it is loaded
    always_comb begin
        state_nx_s = state_r;
        fcnt_nx_s  = 3'd0;
        fcnt_cur_s = ex_branch_taken ? FCNT_LOAD : fcnt_r;
        if (flushing_s) begin
            if (fcnt_cur_s == 3'd0) begin
                state_nx_s = ST_RUN;
                fcnt_nx_s  = 3'd0;
            end else begin
                state_nx_s = ST_FLUSH;
                fcnt_nx_s  = fcnt_cur_s - 3'd1;
            end
        end else if (hazard_s) begin
            state_nx_s = ST_HAZ;
        end else begin
            state_nx_s = ST_RUN;
        end
        // Only an issuing instruction enters EX; stalls and bubbles insert empty
        if (!stall && !bubble) begin
            ex_nx_s = id_info_s;
        end else begin
            ex_nx_s = SB_EMPTY;
        end
    end

    // FSM state, flush countdown and scoreboard slots
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            fcnt_r  <= 3'd0;
            ex_r    <= SB_EMPTY;
            mem_r   <= SB_EMPTY;
        end else begin
            state_r <= state_nx_s;
            fcnt_r  <= fcnt_nx_s;
            ex_r    <= ex_nx_s;
            mem_r   <= ex_r;
        end
    end

    // Saturating debug event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= 16'h0000;
            flush_count_r <= 16'h0000;
        end else begin
            if (stall && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'h0001;
            end
            if (ex_branch_taken && (flush_count_r != 16'hFFFF)) begin
                flush_count_r <= flush_count_r + 16'h0001;
            end
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer: a per-cycle vector table of decoded
// instructions with expected {stall,bubble,flush}, expectations queued when
// driven and compared when sampled, plus hand-written flush/reset sequences.
module tb_pipeline_sequencer;
    import arm_pkg::*;

    typedef struct {
        logic [4:0] op;
        logic [3:0] rn, rd, rm, cond;
        logic       imm, ls, wb, s, lk, br;
        logic [2:0] exp;   // {stall, bubble, flush}
    } vec_t;

    localparam logic [2:0] E_RUN = 3'b000;
    localparam logic [2:0] E_HAZ = 3'b110;
    localparam logic [2:0] E_FL  = 3'b011;
    localparam logic [3:0] EQ    = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dec_opcode;
    logic [3:0]  dec_rn, dec_rd, dec_rm, dec_cond;
    logic        dec_immediateOperand, dec_loadStore, dec_writeBack;
    logic        dec_CPSRwrite, dec_linkBit, ex_branch_taken;
    logic        stall, bubble, flush;
    logic [15:0] stall_count, flush_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];
    vec_t tbl[$];

    pipeline_sequencer #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .dec_opcode(dec_opcode), .dec_rn(dec_rn), .dec_rd(dec_rd), .dec_rm(dec_rm),
        .dec_cond(dec_cond), .dec_immediateOperand(dec_immediateOperand),
        .dec_loadStore(dec_loadStore), .dec_writeBack(dec_writeBack),
        .dec_CPSRwrite(dec_CPSRwrite), .dec_linkBit(dec_linkBit),
        .ex_branch_taken(ex_branch_taken),
        .stall(stall), .bubble(bubble), .flush(flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] op, input logic [3:0] rn,
                                input logic [3:0] rd, input logic [3:0] rm,
                                input logic imm, input logic ls, input logic wb,
                                input logic s, input logic lk, input logic [3:0] cond,
                                input logic br, input logic [2:0] exp);
        vec_t v;
        v.op = op; v.rn = rn; v.rd = rd; v.rm = rm; v.cond = cond;
        v.imm = imm; v.ls = ls; v.wb = wb; v.s = s; v.lk = lk; v.br = br;
        v.exp = exp;
        return v;
    endfunction

    // Data-processing shorthand (AL, no flags, no branch)
    function automatic vec_t dp(input logic [4:0] op, input logic [3:0] rd,
                                input logic [3:0] rn, input logic [3:0] rm,
                                input logic imm, input logic [2:0] exp);
        return mk(op, rn, rd, rm, imm, 1'b0, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, exp);
    endfunction

    function automatic vec_t nop(input logic br, input logic [2:0] exp);
        return mk(OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, COND_AL, br, exp);
    endfunction

    task automatic drive(input vec_t v);
        dec_opcode = v.op; dec_rn = v.rn; dec_rd = v.rd; dec_rm = v.rm;
        dec_cond = v.cond; dec_immediateOperand = v.imm; dec_loadStore = v.ls;
        dec_writeBack = v.wb; dec_CPSRwrite = v.s; dec_linkBit = v.lk;
        ex_branch_taken = v.br;
    endtask

    task automatic cmp_ctl(input string name, input logic [2:0] exp);
        logic [2:0] got;
        got = {stall, bubble, flush};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: stall/bubble/flush got %b expected %b", name, got, exp);
        end
    endtask

    task automatic cmp16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, sample on the falling edge
    task automatic apply(input string name, input vec_t v);
        logic [2:0] e;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp_ctl(name, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // A: ADD r1,r2,r3 ; SUB r4,r1,#1 -> 2 stalls
        tbl.push_back(dp(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, E_RUN));
        tbl.push_back(dp(OP_SUB, 4'd4, 4'd1, 4'd0, 1'b1, E_HAZ));
        tbl.push_back(dp(OP_SUB, 4'd4, 4'd1, 4'd0, 1'b1, E_HAZ));
        tbl.push_back(dp(OP_SUB, 4'd4, 4'd1, 4'd0, 1'b1, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // B: ADD r1 ; MOV r5,#0 (rn field = r1, unused) ; ORR r6,r1,r7 -> 1 stall
        tbl.push_back(dp(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, E_RUN));
        tbl.push_back(dp(OP_MOV, 4'd5, 4'd1, 4'd0, 1'b1, E_RUN));
        tbl.push_back(dp(OP_ORR, 4'd6, 4'd1, 4'd7, 1'b0, E_HAZ));
        tbl.push_back(dp(OP_ORR, 4'd6, 4'd1, 4'd7, 1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // C: independent stream; last has immediate operand with rm = r7 (busy)
        tbl.push_back(dp(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, E_RUN));
        tbl.push_back(dp(OP_SUB, 4'd4, 4'd5, 4'd6, 1'b0, E_RUN));
        tbl.push_back(dp(OP_AND, 4'd7, 4'd8, 4'd9, 1'b0, E_RUN));
        tbl.push_back(dp(OP_EOR, 4'd10, 4'd11, 4'd12, 1'b0, E_RUN));
        tbl.push_back(dp(OP_ADD, 4'd0, 4'd3, 4'd7, 1'b1, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // D: CMP r0,#0 ; ADDEQ r2,r2,#1 -> 1 stall
        tbl.push_back(mk(OP_CMP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, COND_AL, 1'b0, E_RUN));
        tbl.push_back(mk(OP_ADD, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EQ, 1'b0, E_HAZ));
        tbl.push_back(mk(OP_ADD, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, EQ, 1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // E: CMP (rd field r2, not written) ; ADD r2,r2,#1 AL -> 0 stalls
        tbl.push_back(mk(OP_CMP, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, COND_AL, 1'b0, E_RUN));
        tbl.push_back(dp(OP_ADD, 4'd2, 4'd2, 4'd0, 1'b1, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // F: LDR r5,[r7],#4 ; STR r5,[r6] -> 2 stalls
        tbl.push_back(mk(OP_MEM, 4'd7, 4'd5, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, COND_AL, 1'b0, E_RUN));
        tbl.push_back(mk(OP_MEM, 4'd6, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, E_HAZ));
        tbl.push_back(mk(OP_MEM, 4'd6, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, E_HAZ));
        tbl.push_back(mk(OP_MEM, 4'd6, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // G: LDR r5,[r7],#4 ; ADD r8,r7,#0 -> 2 stalls on the write-back
        tbl.push_back(mk(OP_MEM, 4'd7, 4'd5, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, COND_AL, 1'b0, E_RUN));
        tbl.push_back(dp(OP_ADD, 4'd8, 4'd7, 4'd0, 1'b1, E_HAZ));
        tbl.push_back(dp(OP_ADD, 4'd8, 4'd7, 4'd0, 1'b1, E_HAZ));
        tbl.push_back(dp(OP_ADD, 4'd8, 4'd7, 4'd0, 1'b1, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // H: ADD r3,r0,r0 ; LDR r9,[r1,r3] (register offset) -> 2 stalls
        tbl.push_back(dp(OP_ADD, 4'd3, 4'd0, 4'd0, 1'b0, E_RUN));
        tbl.push_back(mk(OP_MEM, 4'd1, 4'd9, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, E_HAZ));
        tbl.push_back(mk(OP_MEM, 4'd1, 4'd9, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, E_HAZ));
        tbl.push_back(mk(OP_MEM, 4'd1, 4'd9, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, COND_AL, 1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        // I: BL (writes r14) ; ADD r0,r14,#0 -> 2 stalls
        tbl.push_back(mk(OP_BR, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, COND_AL, 1'b0, E_RUN));
        tbl.push_back(dp(OP_ADD, 4'd0, 4'd14, 4'd0, 1'b1, E_HAZ));
        tbl.push_back(dp(OP_ADD, 4'd0, 4'd14, 4'd0, 1'b1, E_HAZ));
        tbl.push_back(dp(OP_ADD, 4'd0, 4'd14, 4'd0, 1'b1, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));
        tbl.push_back(nop(1'b0, E_RUN));

        // Reset state
        reset = 1'b0;
        drive(nop(1'b0, E_RUN));
        #3;
        cmp_ctl("reset_outputs", 3'b010);
        cmp16("reset_stall_count", stall_count, 16'd0);
        cmp16("reset_flush_count", flush_count, 16'd0);
        #9 reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);
        cmp16("table_stall_count", stall_count, 16'd12);
        cmp16("table_flush_count", flush_count, 16'd0);

        // Branch taken while a RAW hazard is present: 2 flush cycles, then RUN
        apply("br_producer", dp(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, E_RUN));
        apply("br_pulse", mk(OP_SUB, 4'd1, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                             COND_AL, 1'b1, E_FL));
        apply("br_flush2", nop(1'b0, E_FL));
        apply("br_run", dp(OP_SUB, 4'd4, 4'd1, 4'd0, 1'b1, E_RUN));
        cmp16("br_flush_count", flush_count, 16'd1);
        cmp16("br_stall_count", stall_count, 16'd12);

        // Reset in the middle of a flush with a tracked write to r1
        apply("rst_producer", dp(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, E_RUN));
        apply("rst_pulse", nop(1'b1, E_FL));
        cmp16("rst_pre_flush_count", flush_count, 16'd2);
        drive(nop(1'b1, E_RUN));
        #2 reset = 1'b0;
        #1;
        cmp_ctl("rst_mid_flush", 3'b010);
        cmp16("rst_stall_count", stall_count, 16'd0);
        cmp16("rst_flush_count", flush_count, 16'd0);
        @(negedge clk);
        ex_branch_taken = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply("post_rst_sub_r1", dp(OP_SUB, 4'd4, 4'd1, 4'd0, 1'b1, E_RUN));
        apply("post_rst_add", dp(OP_ADD, 4'd5, 4'd2, 4'd3, 1'b0, E_RUN));
        apply("post_rst_and", dp(OP_AND, 4'd7, 4'd8, 4'd9, 1'b0, E_RUN));
        cmp16("post_rst_stall_count", stall_count, 16'd0);
        cmp16("post_rst_flush_count", flush_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Hazard and flush controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB). Sits beside the instruction decoder and consumes its ID-stage field outputs. Keeps a two-slot scoreboard of in-flight register and CPSR writes, and drives the pipeline's stall, bubble and flush controls. Also keeps saturating stall and flush event counters for debug.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `bubble`/`flush` are held after a taken branch (range 1–7).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `dec_opcode`  in  5  decoded opcode: 00000–01111 = DP, 10000 = load/store, 10001 = branch, 11111 = none.
- `dec_rn`, `dec_rd`, `dec_rm`  in  4 each  decoded register fields.
- `dec_cond`  in  4  condition field.
- `dec_immediateOperand`, `dec_loadStore`, `dec_writeBack`, `dec_CPSRwrite`, `dec_linkBit`  in  1 each  decoded control bits.
- `ex_branch_taken`  in  1  branch in EX resolved taken this cycle.
- `stall`  out  1  hold PC and the IF/ID register.
- `bubble`  out  1  load NOP into the ID/EX register. Must not be looped back into the decoder's noop input.
- `flush`  out  1  clear the IF/ID register.
- `stall_count`  out  16  saturating count of hazard-stall cycles.
- `flush_count`  out  16  saturating count of taken-branch events.

## Operation
- **Source use, DP** (opcode 0xxxx):
  - `rn` is a source unless MOV (01101) or MVN (01111).
  - `rm` is a source when `dec_immediateOperand`=0.
- **Source use, load/store** (10000):
  - `rn` is always a source.
  - `rm` is a source when `dec_immediateOperand`=1 (register offset).
  - `rd` is a source for stores (`dec_loadStore`=0).
- **Source use, branch and 11111:** no sources.
- **Destinations:**
  - DP writes `rd`, except TST/TEQ/CMP/CMN (01000–01011).
  - A load writes `rd`.
  - Load/store with `dec_writeBack`=1 also writes `rn`.
  - A branch with `dec_linkBit`=1 writes r14.
  - Each slot holds up to two destinations (dst0, dst1), each with its own valid bit.
- **Scoreboard:** slots EX and MEM, each {dst0_v, dst0, dst1_v, dst1, cpsr_w}.
  - Every cycle MEM←EX.
  - EX←ID info when issuing (no stall, no bubble); otherwise EX←empty.
  - The register file is write-first in WB, so WB is not tracked.
- **RAW hazard:** any used source equals a valid destination in EX or MEM.
- **Flag hazard:** `dec_cond`≠1110 and EX.cpsr_w=1. Flags are valid once the writer leaves EX.
- **FSM states:** RUN, HAZ, FLUSH; 3-bit countdown `fcnt`.
  - From any state, `ex_branch_taken`=1 → FLUSH, with `fcnt`=FLUSH_CYCLES−1; the current cycle counts as flush cycle 1.
  - FLUSH with `fcnt`=0 → RUN; otherwise decrement `fcnt`.
  - RUN/HAZ → HAZ when a hazard is present, else RUN.
- **Outputs** (combinational from state and inputs):
  - FLUSH, or `ex_branch_taken` this cycle: `bubble`=1, `flush`=1, `stall`=0. Flush wins over hazards.
  - Hazard (not flushing): `stall`=1, `bubble`=1, `flush`=0.
  - Otherwise all three are 0.
- **Counters:**
  - `stall_count` +1 per cycle with `stall`=1.
  - `flush_count` +1 per `ex_branch_taken` pulse.
  - Both saturate at 16'hFFFF.

## Timing
- Reset (low): state RUN, scoreboard empty, `fcnt`=0, counters 0.
  - While reset is low: `bubble`=1, `stall`=0, `flush`=0.
- Reset mid-FLUSH or mid-HAZ aborts immediately; the first cycle after release is RUN with an empty scoreboard.
- Hazard decision is zero-latency (same cycle as the ID fields).
- A dependent instruction stalls:
  - 2 cycles when the producer is directly ahead;
  - 1 cycle with one instruction between.
- Flag hazard stalls exactly 1 cycle.
- A branch held in EX during a flush still advances to MEM, so BL's r14 write stays tracked.
- The stalled ID instruction reissues unchanged; its fields must be held stable by the IF/ID register.

## Structure
- Shared package `arm_pkg`:
  - opcode constants OP_AND…OP_MVN, OP_MEM=10000, OP_BR=10001, OP_NOP=11111;
  - COND_AL=4'b1110;
  - FSM state enum;
  - scoreboard slot struct.
- Sub-module `reg_use_decode` (combinational): decoded fields → use_rn/use_rm/use_rd, dst0/dst1 with valid bits, cpsr_w. Instantiated once.

## Test plan
- ADD r1,r2,r3 then SUB r4,r1,#1 → `stall`=`bubble`=1 for 2 cycles, SUB issues on cycle 3, `stall_count`=2.
- ADD r1,r2,r3; MOV r5,#0; ORR r6,r1,r7 → ORR stalls 1 cycle. Independent stream → `stall` never asserts.
- CMP r0,#0 then ADDEQ r2,r2,#1 → exactly 1 stall cycle. Same pair with ADD (AL) → 0 stalls.
- LDR r5,[r7],#4 (writeBack) then STR r5,[r6] → 2 stalls. Then ADD r8,r7,#0 → stalls on the r7 write-back.
- `ex_branch_taken` pulse while a RAW hazard is present, FLUSH_CYCLES=2:
  - `bubble`=`flush`=1, `stall`=0 for 2 cycles;
  - `flush_count`=1;
  - then RUN.
- Reset asserted during FLUSH with counters nonzero → same cycle `bubble`=1, `stall`=0, counters 0. After release: RUN, no stalls for independent code.
